// File: rtl/status_collector_pkg.sv
// Shared definitions for the status collector: code width, terminal codes,
// collector FSM states and a terminal-code helper.
package status_pkg;

    localparam int unsigned STAT_W = 3;

    localparam logic [STAT_W-1:0] ST_INVALID = 3'd5;
    localparam logic [STAT_W-1:0] ST_EOF     = 3'd6;

    typedef enum logic {
        CAPTURE = 1'b0,
        DONE    = 1'b1
    } coll_state_t;

    function automatic logic is_terminal(input logic [STAT_W-1:0] code);
        return (code == ST_INVALID) || (code == ST_EOF);
    endfunction

endpackage

// File: rtl/status_collector_fifo.sv
// DEPTH x W synchronous FIFO with registered read port. Occupancy is the
// difference of two (log2(DEPTH)+1)-bit counters so full and empty are
// distinguishable. A push while full is accepted only if a pop frees a slot
// in the same cycle; a pop while empty is ignored (no bypass).
module status_fifo #(
    parameter int unsigned DEPTH = 512,
    parameter int unsigned W     = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   push,
    input  logic [W-1:0]           wr_data,
    input  logic                   pop,
    output logic [W-1:0]           rd_data,
    output logic                   rd_valid,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level,
    output logic                   drop
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]  wr_cnt;
    logic [AW:0]  rd_cnt;
    logic [W-1:0] mem [DEPTH];
    logic         pop_ok;
    logic         push_ok;

    // Occupancy, flags and accept decisions
    always_comb begin
        level   = wr_cnt - rd_cnt;
        empty   = (level == '0);
        full    = (level == (AW+1)'(DEPTH));
        pop_ok  = pop && !empty;
        push_ok = push && (!full || pop_ok);
        drop    = push && !push_ok;
    end

    // Read/write counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else if (clear) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            if (push_ok) wr_cnt <= wr_cnt + (AW+1)'(1);
            if (pop_ok)  rd_cnt <= rd_cnt + (AW+1)'(1);
        end
    end

    // Storage array, left unreset so it can map onto block RAM
    always_ff @(posedge clk) begin
        if (push_ok && !clear) mem[wr_cnt[AW-1:0]] <= wr_data;
    end

    // Registered read data and one-cycle valid pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else if (clear) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= pop_ok;
            if (pop_ok) rd_data <= mem[rd_cnt[AW-1:0]];
        end
    end

endmodule

// File: rtl/status_collector.sv
// Status stream sink: captures codes into a FIFO, ends the run on a terminal
// code (INVALID/EOF) or idle timeout, and keeps sticky fault flags and a
// saturating total count. Optional per-code histogram when STATUS_HIST_EN
// is defined.
module status_collector
    import status_pkg::*;
#(
    parameter int unsigned DEPTH       = 512,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [STAT_W-1:0]      i_status,
    input  logic                   i_status_valid,
    input  logic                   i_clear,
    input  logic                   i_rd_en,
    output logic [STAT_W-1:0]      o_rd_data,
    output logic                   o_rd_valid,
    output logic                   o_empty,
    output logic                   o_full,
    output logic [$clog2(DEPTH):0] o_level,
    output logic                   o_done,
    output logic [STAT_W-1:0]      o_term_code,
    output logic                   o_overflow,
    output logic                   o_timeout,
    output logic                   o_protocol_err,
    output logic [CNT_W-1:0]       o_total_cnt
`ifdef STATUS_HIST_EN
    ,
    input  logic [STAT_W-1:0]      i_hist_sel,
    output logic [CNT_W-1:0]       o_hist_cnt
`endif
);

    localparam int unsigned IW = $clog2(TIMEOUT_CYC + 1);

    coll_state_t   state;
    coll_state_t   state_nxt;
    logic [IW-1:0] idle_cnt;
    logic          capture_valid;
    logic          idle_hit;
    logic          drop;

    status_fifo #(
        .DEPTH (DEPTH),
        .W     (STAT_W)
    ) u_fifo (
        .clk      (i_clk),
        .rst      (i_rst),
        .clear    (i_clear),
        .push     (capture_valid),
        .wr_data  (i_status),
        .pop      (i_rd_en),
        .rd_data  (o_rd_data),
        .rd_valid (o_rd_valid),
        .empty    (o_empty),
        .full     (o_full),
        .level    (o_level),
        .drop     (drop)
    );

    assign capture_valid = i_status_valid && (state == CAPTURE);
    assign idle_hit      = !i_status_valid && (state == CAPTURE) &&
                           (idle_cnt == IW'(TIMEOUT_CYC - 1));
    assign o_done        = (state == DONE);

    // Next-state: terminal code or idle timeout ends the run; only clear restarts it
    always_comb begin
        state_nxt = state;
        if (i_clear) begin
            state_nxt = CAPTURE;
        end else if (state == CAPTURE) begin
            if (i_status_valid && is_terminal(i_status)) state_nxt = DONE;
            else if (idle_hit)                           state_nxt = DONE;
        end
    end

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= CAPTURE;
        else       state <= state_nxt;
    end

    // Idle timer: counts consecutive no-valid cycles while capturing
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                                   idle_cnt <= '0;
        else if (i_clear || i_status_valid || o_done) idle_cnt <= '0;
        else                                         idle_cnt <= idle_cnt + IW'(1);
    end

    // Terminal code latch, sticky flags and saturating total count
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_term_code    <= '0;
            o_overflow     <= 1'b0;
            o_timeout      <= 1'b0;
            o_protocol_err <= 1'b0;
            o_total_cnt    <= '0;
        end else if (i_clear) begin
            o_term_code    <= '0;
            o_overflow     <= 1'b0;
            o_timeout      <= 1'b0;
            o_protocol_err <= 1'b0;
            o_total_cnt    <= '0;
        end else begin
            if (capture_valid && is_terminal(i_status)) o_term_code <= i_status;
            if (capture_valid && drop)                  o_overflow <= 1'b1;
            if (idle_hit)                               o_timeout <= 1'b1;
            if (i_status_valid && o_done)               o_protocol_err <= 1'b1;
            if (capture_valid && (o_total_cnt != '1))   o_total_cnt <= o_total_cnt + CNT_W'(1);
        end
    end

`ifdef STATUS_HIST_EN
    logic [CNT_W-1:0] hist [2**STAT_W];

    // Per-code saturating histogram over the codes counted in o_total_cnt
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < 2**STAT_W; i++) hist[i] <= '0;
        end else if (i_clear) begin
            for (int unsigned i = 0; i < 2**STAT_W; i++) hist[i] <= '0;
        end else if (capture_valid && (hist[i_status] != '1)) begin
            hist[i_status] <= hist[i_status] + CNT_W'(1);
        end
    end

    assign o_hist_cnt = hist[i_hist_sel];
`endif

endmodule

// File: tb/tb_status_collector.sv
// Self-checking bench for status_collector (DEPTH=512, TIMEOUT_CYC=16).
// Histogram checks are compiled in when STATUS_HIST_EN is defined.
module tb_status_collector;

    localparam int DEPTH = 512;
    localparam int TMO   = 16;
    localparam int CMAX  = 65535;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  status;
    logic        valid;
    logic        clear;
    logic        rd_en;
    logic [2:0]  rd_data;
    logic        rd_valid;
    logic        empty;
    logic        full;
    logic [9:0]  level;
    logic        done;
    logic [2:0]  term_code;
    logic        overflow;
    logic        timeout;
    logic        protocol_err;
    logic [15:0] total_cnt;
`ifdef STATUS_HIST_EN
    logic [2:0]  hist_sel;
    logic [15:0] hist_cnt;
`endif

    status_collector #(
        .DEPTH       (DEPTH),
        .CNT_W       (16),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_status       (status),
        .i_status_valid (valid),
        .i_clear        (clear),
        .i_rd_en        (rd_en),
        .o_rd_data      (rd_data),
        .o_rd_valid     (rd_valid),
        .o_empty        (empty),
        .o_full         (full),
        .o_level        (level),
        .o_done         (done),
        .o_term_code    (term_code),
        .o_overflow     (overflow),
        .o_timeout      (timeout),
        .o_protocol_err (protocol_err),
        .o_total_cnt    (total_cnt)
`ifdef STATUS_HIST_EN
        ,
        .i_hist_sel     (hist_sel),
        .o_hist_cnt     (hist_cnt)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue holds FIFO contents, plain ints hold the rest
    int q[$];
    bit m_done;
    int m_term, m_ovf, m_to, m_perr, m_total, m_idle, m_rdv, m_rdd;
    int m_hist[8];

    task automatic m_reset();
        q.delete();
        m_done = 0; m_term = 0; m_ovf = 0; m_to = 0; m_perr = 0;
        m_total = 0; m_idle = 0; m_rdv = 0; m_rdd = 0;
        foreach (m_hist[i]) m_hist[i] = 0;
    endtask

    task automatic m_step();
        bit was_done, pop_ok, room;
        if (rst || clear) begin
            m_reset();
            return;
        end
        was_done = m_done;
        pop_ok   = rd_en && (q.size() > 0);
        room     = q.size() < DEPTH;
        m_rdv    = pop_ok;
        if (pop_ok) m_rdd = q.pop_front();
        if (valid && !was_done) begin
            if (m_total < CMAX) m_total++;
            if (m_hist[status] < CMAX) m_hist[status]++;
            if (room || pop_ok) q.push_back(int'(status));
            else m_ovf = 1;
            if (status == 3'd5 || status == 3'd6) begin
                m_done = 1;
                m_term = int'(status);
            end
            m_idle = 0;
        end else if (!was_done) begin
            m_idle++;
            if (m_idle == TMO) begin
                m_to = 1;
                m_done = 1;
            end
        end
        if (valid && was_done) m_perr = 1;
    endtask

    // Advance one clock: update the model with the inputs in force, then sample after the edge
    task automatic tick();
        m_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model();
        chk("m_level", 32'(level), q.size());
        chk("m_empty", 32'(empty), (q.size() == 0));
        chk("m_full", 32'(full), (q.size() == DEPTH));
        chk("m_done", 32'(done), m_done);
        chk("m_term", 32'(term_code), m_term);
        chk("m_ovf", 32'(overflow), m_ovf);
        chk("m_timeout", 32'(timeout), m_to);
        chk("m_perr", 32'(protocol_err), m_perr);
        chk("m_total", 32'(total_cnt), m_total);
        chk("m_rd_valid", 32'(rd_valid), m_rdv);
        chk("m_rd_data", 32'(rd_data), m_rdd);
`ifdef STATUS_HIST_EN
        chk("m_hist", 32'(hist_cnt), m_hist[hist_sel]);
`endif
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_level"}, 32'(level), 0);
        chk({tag, "_empty"}, 32'(empty), 1);
        chk({tag, "_full"}, 32'(full), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_term"}, 32'(term_code), 0);
        chk({tag, "_flags"}, {29'd0, overflow, timeout, protocol_err}, 0);
        chk({tag, "_total"}, 32'(total_cnt), 0);
        chk({tag, "_rd_valid"}, 32'(rd_valid), 0);
        chk({tag, "_rd_data"}, 32'(rd_data), 0);
    endtask

    typedef struct {
        logic       valid;
        logic [2:0] code;
        logic       rd;
        int         e_level;
        int         e_done;
        int         e_term;
        int         e_rdv;
        int         e_rdd;
    } vec_t;

    vec_t vecs[9];

    initial begin
        rst = 1'b1; status = '0; valid = 1'b0; clear = 1'b0; rd_en = 1'b0;
`ifdef STATUS_HIST_EN
        hist_sel = '0;
`endif
        m_reset();

        // Reset mid-capture after three codes
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            status = 3'(i + 1);
            tick();
        end
        chk("pre_reset_level", 32'(level), 3);
        #3;
        rst = 1'b1;
        m_reset();
        #1;
        check_all_zero("async_rst");
        @(posedge clk);
        #1;
        check_all_zero("held_rst");
        @(negedge clk);
        rst = 1'b0;
        valid = 1'b0;

        // Push 0,1,2,6 then pop four
        vecs[0] = '{1'b1, 3'd0, 1'b0, 1, 0, 0, 0, 0};
        vecs[1] = '{1'b1, 3'd1, 1'b0, 2, 0, 0, 0, 0};
        vecs[2] = '{1'b1, 3'd2, 1'b0, 3, 0, 0, 0, 0};
        vecs[3] = '{1'b1, 3'd6, 1'b0, 4, 1, 6, 0, 0};
        vecs[4] = '{1'b0, 3'd0, 1'b1, 3, 1, 6, 1, 0};
        vecs[5] = '{1'b0, 3'd0, 1'b1, 2, 1, 6, 1, 1};
        vecs[6] = '{1'b0, 3'd0, 1'b1, 1, 1, 6, 1, 2};
        vecs[7] = '{1'b0, 3'd0, 1'b1, 0, 1, 6, 1, 6};
        vecs[8] = '{1'b0, 3'd0, 1'b1, 0, 1, 6, 0, 6};
        foreach (vecs[i]) begin
            valid = vecs[i].valid;
            status = vecs[i].code;
            rd_en = vecs[i].rd;
            tick();
            chk($sformatf("vec%0d_level", i), 32'(level), vecs[i].e_level);
            chk($sformatf("vec%0d_done", i), 32'(done), vecs[i].e_done);
            chk($sformatf("vec%0d_term", i), 32'(term_code), vecs[i].e_term);
            chk($sformatf("vec%0d_rd_valid", i), 32'(rd_valid), vecs[i].e_rdv);
            if (vecs[i].e_rdv != 0)
                chk($sformatf("vec%0d_rd_data", i), 32'(rd_data), vecs[i].e_rdd);
        end
        chk("vec_empty", 32'(empty), 1);
        rd_en = 1'b0;

        // Fill to full, overflow, simultaneous push+pop, terminal dropped on full
        clear = 1'b1; tick(); clear = 1'b0;
        check_all_zero("clear1");
        valid = 1'b1; status = 3'd1;
        for (int i = 0; i < DEPTH; i++) tick();
        chk("fill_full", 32'(full), 1);
        chk("fill_level", 32'(level), DEPTH);
        chk("fill_ovf", 32'(overflow), 0);
        status = 3'd2; tick();
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_level", 32'(level), DEPTH);
        chk("ovf_total", 32'(total_cnt), 513);
        status = 3'd3; rd_en = 1'b1; tick();
        chk("pp_level", 32'(level), DEPTH);
        chk("pp_rd_valid", 32'(rd_valid), 1);
        chk("pp_rd_data", 32'(rd_data), 1);
        chk("pp_total", 32'(total_cnt), 514);
        rd_en = 1'b0; status = 3'd5; tick();
        chk("dropterm_done", 32'(done), 1);
        chk("dropterm_term", 32'(term_code), 5);
        chk("dropterm_level", 32'(level), DEPTH);
        check_model();

        // Valid after EOF raises protocol error without side effects
        valid = 1'b0; clear = 1'b1; tick(); clear = 1'b0;
        valid = 1'b1; status = 3'd4; tick();
        status = 3'd6; tick();
        chk("eof_done", 32'(done), 1);
        status = 3'd3; tick(); tick();
        valid = 1'b0;
        chk("perr_flag", 32'(protocol_err), 1);
        chk("perr_level", 32'(level), 2);
        chk("perr_total", 32'(total_cnt), 2);
        clear = 1'b1; tick(); clear = 1'b0;
        check_all_zero("clear2");

        // Idle timeout
        for (int i = 0; i < TMO - 1; i++) tick();
        chk("tmo_early", 32'(timeout), 0);
        chk("tmo_early_done", 32'(done), 0);
        tick();
        chk("tmo_flag", 32'(timeout), 1);
        chk("tmo_done", 32'(done), 1);
        chk("tmo_term", 32'(term_code), 0);

`ifdef STATUS_HIST_EN
        // Histogram of 3,3,5
        clear = 1'b1; tick(); clear = 1'b0;
        valid = 1'b1;
        status = 3'd3; tick(); tick();
        status = 3'd5; tick();
        valid = 1'b0;
        hist_sel = 3'd3; #1; chk("hist3", 32'(hist_cnt), 2);
        hist_sel = 3'd5; #1; chk("hist5", 32'(hist_cnt), 1);
        hist_sel = 3'd6; #1; chk("hist6", 32'(hist_cnt), 0);
`endif

        // Randomized traffic against the model
        clear = 1'b1; tick(); clear = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            valid = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 99) < 2) status = 3'($urandom_range(5, 6));
            else status = 3'($urandom_range(0, 4));
            if ($urandom_range(0, 99) < 3) status = 3'd7;
            rd_en = $urandom_range(0, 1);
            clear = ($urandom_range(0, 149) == 0);
`ifdef STATUS_HIST_EN
            hist_sel = 3'($urandom_range(0, 7));
`endif
            tick();
            check_model();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
